// File: rtl/ahb_slave_port_arbiter.sv
// ==========================================================================
// ahb_slave_port_arbiter: grants one AHB master at a time to a shared slave port.
// Defining AHB_ARB_FIXED_PRIO_EN selects fixed priority; the default is round robin. Rev 1.0
// ==========================================================================
`default_nettype none

module ahb_slave_port_arbiter #(
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_W       = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [CHANNEL_NUM-1:0]     req,
  input  logic [2*CHANNEL_NUM-1:0]   htrans,
  input  logic [3*CHANNEL_NUM-1:0]   hburst,
  input  logic [CHANNEL_NUM-1:0]     hmastlock,
  input  logic                       hready,
  output logic [CHANNEL_NUM-1:0]     addr_sel,
  output logic [CHANNEL_NUM-1:0]     data_sel,
  output logic                       hsel_slv,
  output logic [CHANNEL_NUM-1:0]     wait_req
);

  localparam logic [1:0] c_HTRANS_IDLE = 2'b00;
  localparam logic [1:0] c_HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] c_HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] c_HBURST_INCR4  = 3'b011;
  localparam logic [2:0] c_HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] c_HBURST_INCR8  = 3'b101;
  localparam logic [2:0] c_HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] c_HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CHANNEL_NUM-1:0]  r_addr_sel;
  logic [CHANNEL_NUM-1:0]  r_data_sel;
  logic [CNT_W-1:0]        r_cnt;

  logic [CHANNEL_NUM-1:0]  w_addr_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_rearb;
  logic                    w_end;
  logic                    w_grant;

  logic [1:0]              w_own_trans;
  logic                    w_own_lock;
  logic                    w_own_seq;
  logic [CHANNEL_NUM-1:0]  w_req_eff;

  logic [CHANNEL_NUM-1:0]  w_win_oh;
  logic                    w_win_found;
  logic [2:0]              w_win_burst;
  logic                    w_win_lock;
  logic                    w_win_is_burst;
  logic [CNT_W-1:0]        w_win_len;

  // Owner's transfer attributes, selected by the one-hot address-phase owner
  always_comb begin
    w_own_trans = '0;
    w_own_lock  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (r_addr_sel[i]) begin
        w_own_trans = w_own_trans | htrans[2*i +: 2];
        w_own_lock  = w_own_lock  | hmastlock[i];
      end
    end
  end

  // A SEQ beat from the owner is the tail of its own burst, never a fresh request
  assign w_own_seq = (|r_addr_sel) && (w_own_trans == c_HTRANS_SEQ);
  assign w_req_eff = req & ~(r_addr_sel & {CHANNEL_NUM{w_own_seq}});

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win_oh    = '0;
    w_win_found = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (!w_win_found && w_req_eff[i]) begin
        w_win_found = 1'b1;
        w_win_oh[i] = 1'b1;
      end
    end
  end
`else
  localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  int               w_j;

  // Rotating search starting at the pointer
  always_comb begin
    w_win_oh    = '0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_j         = 0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= CHANNEL_NUM) begin
        w_j = w_j - CHANNEL_NUM;
      end
      if (!w_win_found && w_req_eff[w_j]) begin
        w_win_found   = 1'b1;
        w_win_idx     = IDX_W'(w_j);
        w_win_oh[w_j] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0 : (w_win_idx + IDX_W'(1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ptr <= '0;
    end else if (hready && w_grant) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  always_comb begin
    w_win_burst = '0;
    w_win_lock  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (w_win_oh[i]) begin
        w_win_burst = w_win_burst | hburst[3*i +: 3];
        w_win_lock  = w_win_lock  | hmastlock[i];
      end
    end
  end

  // Remaining SEQ beats after the NONSEQ; undefined-length INCR is arbitrated like a single
  always_comb begin
    w_win_is_burst = 1'b1;
    w_win_len      = '0;
    case (w_win_burst)
      c_HBURST_WRAP4,  c_HBURST_INCR4:  w_win_len = CNT_W'(3);
      c_HBURST_WRAP8,  c_HBURST_INCR8:  w_win_len = CNT_W'(7);
      c_HBURST_WRAP16, c_HBURST_INCR16: w_win_len = CNT_W'(15);
      default:                          w_win_is_burst = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr_sel;
    w_cnt_nxt   = r_cnt;
    w_rearb     = 1'b0;
    w_end       = 1'b0;

    case (r_state)
      ST_IDLE, ST_SINGLE: begin
        w_rearb = 1'b1;
      end
      ST_BURST: begin
        if (w_own_trans == c_HTRANS_IDLE) begin
          w_end = 1'b1;
        end else if (w_own_trans == c_HTRANS_SEQ) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_end = 1'b1;
          end
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        // A still-locked owner keeps the port past the end of its burst
        if (w_end) begin
          if (w_own_lock) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_rearb = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if ((w_own_trans == c_HTRANS_SEQ) && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        if (!w_own_lock) begin
          w_rearb = 1'b1;
        end
      end
      default: begin
        w_rearb = 1'b1;
      end
    endcase

    if (w_rearb) begin
      if (w_win_found) begin
        w_addr_nxt = w_win_oh;
        w_cnt_nxt  = w_win_len;
        if (w_win_is_burst) begin
          w_state_nxt = ST_BURST;
        end else if (w_win_lock) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_SINGLE;
        end
      end else begin
        w_addr_nxt  = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign w_grant = w_rearb && w_win_found;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_addr_sel <= '0;
      r_data_sel <= '0;
      r_cnt      <= '0;
    end else if (hready) begin
      r_state    <= w_state_nxt;
      r_addr_sel <= w_addr_nxt;
      r_data_sel <= r_addr_sel;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign addr_sel = r_addr_sel;
  assign data_sel = r_data_sel;
  assign hsel_slv = |(r_addr_sel & req);
  // Forced low while reset is asserted, even if masters keep requesting
  assign wait_req = req & ~r_addr_sel & {CHANNEL_NUM{HRESETn}};

  a_sel_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot0(r_addr_sel) && $onehot0(r_data_sel));

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_port_arbiter.sv
// ==========================================================================
// tb_ahb_slave_port_arbiter: directed vectors with a queue-based scoreboard. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_ahb_slave_port_arbiter;

  localparam logic [1:0] HT_I = 2'b00;
  localparam logic [1:0] HT_N = 2'b10;
  localparam logic [1:0] HT_S = 2'b11;
  localparam logic [2:0] HB_S   = 3'b000;
  localparam logic [2:0] HB_I4  = 3'b011;
  localparam logic [2:0] HB_I8  = 3'b101;
  localparam logic [2:0] HB_I16 = 3'b111;
  localparam logic [7:0]  TR0 = 8'h00;
  localparam logic [11:0] HB0 = 12'h000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [3:0]  req;
  logic [7:0]  htrans;
  logic [11:0] hburst;
  logic [3:0]  hmastlock;
  logic        hready;
  logic [3:0]  addr_sel;
  logic [3:0]  data_sel;
  logic        hsel_slv;
  logic [3:0]  wait_req;

  always #5 HCLK = ~HCLK;

  ahb_slave_port_arbiter #(.CHANNEL_NUM(4), .CNT_W(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req       (req),
    .htrans    (htrans),
    .hburst    (hburst),
    .hmastlock (hmastlock),
    .hready    (hready),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel),
    .hsel_slv  (hsel_slv),
    .wait_req  (wait_req)
  );

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [3:0] data;
    logic [3:0] wt;
    logic       hsel;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_cnt  = 0;

  logic [3:0] m_prev_ea = 4'b0;
  logic [3:0] m_prev_ed = 4'b0;
  logic       m_prev_hr = 1'b0;

  always @(posedge HCLK) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [7:0] tr4(input logic [1:0] t3, t2, t1, t0);
    return {t3, t2, t1, t0};
  endfunction

  function automatic logic [11:0] hb4(input logic [2:0] b3, b2, b1, b0);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string nm, input int c, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, c, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic row(input logic rs, input logic [3:0] rq, input logic [7:0] tr,
                     input logic [11:0] hb, input logic [3:0] lk, input logic hr,
                     input logic [3:0] ea);
    exp_t       e;
    logic [3:0] ed;
    ed = m_prev_hr ? m_prev_ea : m_prev_ed;
    if (!rs) ed = 4'b0;
    HRESETn   = rs;
    req       = rq;
    htrans    = tr;
    hburst    = hb;
    hmastlock = lk;
    hready    = hr;
    e.cyc  = cyc_cnt;
    e.addr = ea;
    e.data = ed;
    e.wt   = rq & ~ea & {4{rs}};
    e.hsel = |(ea & rq);
    q.push_back(e);
    m_prev_hr = hr;
    m_prev_ea = ea;
    m_prev_ed = ed;
    @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      if (e.cyc != cyc_cnt) begin
        checks++;
        failures++;
        $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc_cnt, cyc_cnt, e.cyc);
      end else begin
        chk("addr_sel", e.cyc, addr_sel, e.addr);
        chk("data_sel", e.cyc, data_sel, e.data);
        chk("wait_req", e.cyc, wait_req, e.wt);
        chk("hsel_slv", e.cyc, {3'b000, hsel_slv}, {3'b000, e.hsel});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; req = '0; htrans = '0; hburst = '0; hmastlock = '0; hready = 1'b1;
    @(posedge HCLK);
    #1;
    // Reset: outputs quiet even with requests present
    row(0, 4'b1010, tr4(HT_N, HT_I, HT_N, HT_I), HB0, 4'b0000, 1, 4'b0000);
    row(0, 4'b1010, tr4(HT_N, HT_I, HT_N, HT_I), HB0, 4'b0000, 1, 4'b0000);
    // Singles from masters 1 and 3
    row(1, 4'b1010, tr4(HT_N, HT_I, HT_N, HT_I), HB0, 4'b0000, 1, 4'b0000);
    row(1, 4'b1010, tr4(HT_N, HT_I, HT_N, HT_I), HB0, 4'b0000, 1, 4'b0010);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b1000);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    // Master 0 INCR4 with master 2 waiting
    row(1, 4'b0101, tr4(HT_I, HT_N, HT_I, HT_N), hb4(HB_S, HB_S, HB_S, HB_I4), 4'b0000, 1, 4'b0000);
    row(1, 4'b0101, tr4(HT_I, HT_N, HT_I, HT_N), hb4(HB_S, HB_S, HB_S, HB_I4), 4'b0000, 1, 4'b0001);
    for (int i = 0; i < 3; i++)
      row(1, 4'b0101, tr4(HT_I, HT_N, HT_I, HT_S), hb4(HB_S, HB_S, HB_S, HB_I4), 4'b0000, 1, 4'b0001);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0100);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    // Master 1 INCR8 with a 3-cycle wait at beat 3, master 3 waiting
    row(1, 4'b0010, tr4(HT_I, HT_I, HT_N, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0000);
    row(1, 4'b0010, tr4(HT_I, HT_I, HT_N, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0010);
    row(1, 4'b1010, tr4(HT_N, HT_I, HT_S, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0010);
    for (int i = 0; i < 3; i++)
      row(1, 4'b1010, tr4(HT_N, HT_I, HT_S, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 0, 4'b0010);
    for (int i = 0; i < 6; i++)
      row(1, 4'b1010, tr4(HT_N, HT_I, HT_S, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0010);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b1000);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    // Master 3 locked sequence against masters 0..2
    row(1, 4'b1000, tr4(HT_N, HT_I, HT_I, HT_I), HB0, 4'b1000, 1, 4'b0000);
    for (int i = 0; i < 5; i++)
      row(1, 4'b1111, tr4(HT_N, HT_N, HT_N, HT_N), HB0, 4'b1000, 1, 4'b1000);
    row(1, 4'b0111, tr4(HT_I, HT_N, HT_N, HT_N), HB0, 4'b0000, 1, 4'b1000);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 0, 4'b0001);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0001);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    // Master 2 INCR16 cut short by IDLE after 5 beats
    row(1, 4'b0100, tr4(HT_I, HT_N, HT_I, HT_I), hb4(HB_S, HB_I16, HB_S, HB_S), 4'b0000, 1, 4'b0000);
    row(1, 4'b0100, tr4(HT_I, HT_N, HT_I, HT_I), hb4(HB_S, HB_I16, HB_S, HB_S), 4'b0000, 1, 4'b0100);
    for (int i = 0; i < 4; i++)
      row(1, 4'b0100, tr4(HT_I, HT_S, HT_I, HT_I), hb4(HB_S, HB_I16, HB_S, HB_S), 4'b0000, 1, 4'b0100);
    row(1, 4'b1011, tr4(HT_N, HT_I, HT_N, HT_N), hb4(HB_S, HB_I16, HB_S, HB_S), 4'b0000, 1, 4'b0100);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b1000);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    // Reset pulse in the middle of a master 1 INCR8
    row(1, 4'b0010, tr4(HT_I, HT_I, HT_N, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0000);
    row(1, 4'b0010, tr4(HT_I, HT_I, HT_N, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0010);
    row(1, 4'b0010, tr4(HT_I, HT_I, HT_S, HT_I), hb4(HB_S, HB_S, HB_I8, HB_S), 4'b0000, 1, 4'b0010);
    row(0, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    row(0, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);
    row(1, 4'b0001, tr4(HT_I, HT_I, HT_I, HT_N), HB0, 4'b0000, 1, 4'b0000);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0001);
    row(1, 4'b0000, TR0, HB0, 4'b0000, 1, 4'b0000);

    @(negedge HCLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
